// File: rtl/pll_reset_ce_gen.sv
// -----------------------------------------------------------------------------
// pll_reset_ce_gen
//
// Reset sequencer and clock-enable generator that sits right after the system
// PLL. The core is held in reset until the PLL lock has been stable for
// SETTLE_CYCLES cycles. Once released, the block produces phase-aligned
// single-cycle pixel and CPU clock enables.
//
// Optional feature macro: PLL_LOCK_LOSS_EN
//   defined     : losing lock while running drops back to WAIT_LOCK, re-asserts
//                 rst_out and sets the sticky lock_lost flag.
//   not defined : RUN is terminal until reset; lock_lost is tied low.
//
// Parameters
//   SETTLE_CYCLES : stable-lock cycles required before release (>= 2)
//   PIX_DIV       : ce_pix period in clk_sys cycles (power of two, >= 2)
//   CPU_DIV       : ce_cpu period in clk_sys cycles (power of two, multiple
//                   of PIX_DIV)
//
// Ports
//   clk_sys   in  : PLL output clock, all logic on its rising edge
//   reset     in  : synchronous active-high reset
//   locked    in  : PLL lock status, asynchronous to clk_sys
//   rst_out   out : active-high reset for the downstream core
//   ce_pix    out : single-cycle pixel enable
//   ce_cpu    out : single-cycle CPU enable (always coincides with ce_pix)
//   lock_sync out : locked after the two-flop synchronizer
//   lock_lost out : sticky flag, lock dropped after RUN was reached
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pll_reset_ce_gen #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int PIX_DIV       = 4,
    parameter int CPU_DIV       = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic locked,
    output logic rst_out,
    output logic ce_pix,
    output logic ce_cpu,
    output logic lock_sync,
    output logic lock_lost
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int DIV_W = $clog2(CPU_DIV);
    localparam int PIX_W = $clog2(PIX_DIV);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CPU_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             run_q;

    // ---- synchronizer stage: locked -> s1 -> s2 ----
    always_comb begin
        s1_d = locked;
        s2_d = s1_q;
    end

    // ---- FSM next state and settle counter ----
`ifdef PLL_LOCK_LOSS_EN
    logic lost_q, lost_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
`ifdef PLL_LOCK_LOSS_EN
        lost_d  = lost_q;
`endif
        case (state_q)
            WAIT_LOCK: begin
                if (s2_q) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!s2_q) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == SETTLE_LAST) begin
                    // Counter stays parked at its last value instead of wrapping.
                    state_d = RUN;
                    cnt_d   = cnt_q;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = cnt_q;
`ifdef PLL_LOCK_LOSS_EN
                if (!s2_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                end
`endif
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // ---- enable divider: zero outside RUN, free-running modulo CPU_DIV inside ----
    always_comb begin
        div_d = '0;
        if ((state_q == RUN) && (state_d == RUN)) begin
            div_d = div_q + 1'b1;
        end
    end

    // ---- state registers ----
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
        end
    end

`ifdef PLL_LOCK_LOSS_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lost_q <= 1'b0;
        end else begin
            lost_q <= lost_d;
        end
    end

    assign lock_lost = lost_q;
`else
    assign lock_lost = 1'b0;
`endif

    // ---- output decode: registered state only, no path from inputs ----
    assign run_q     = (state_q == RUN);
    assign rst_out   = !run_q;
    assign ce_pix    = run_q && (&div_q[PIX_W-1:0]);
    assign ce_cpu    = run_q && (div_q == DIV_LAST);
    assign lock_sync = s2_q;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
`timescale 1ns/1ps
module tb_pll_reset_ce_gen;

    localparam int SETTLE = 16;
    localparam int PIX    = 4;
    localparam int CPU    = 8;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic locked  = 1'b0;
    logic rst_out;
    logic ce_pix;
    logic ce_cpu;
    logic lock_sync;
    logic lock_lost;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic rst_out;
        logic ce_pix;
        logic ce_cpu;
        logic lock_sync;
        logic lock_lost;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string name;
        logic  r;
        logic  lk;
        int    n;
        logic  e_rst;
        logic  e_pix;
        logic  e_cpu;
        logic  e_sync;
        logic  e_lost;
    } vec_t;

    vec_t vecs[6];

    // Reference model state: phase 0=wait, 1=settle, 2=run.
    // m_run counts cycles spent in run; enables are derived from it arithmetically.
    int   m_phase = 0;
    int   m_cnt   = 0;
    int   m_run   = 0;
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;
    logic m_lost  = 1'b0;

    pll_reset_ce_gen #(
        .SETTLE_CYCLES(SETTLE),
        .PIX_DIV      (PIX),
        .CPU_DIV      (CPU)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .locked   (locked),
        .rst_out  (rst_out),
        .ce_pix   (ce_pix),
        .ce_cpu   (ce_cpu),
        .lock_sync(lock_sync),
        .lock_lost(lock_lost)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic lk);
        logic old_s2;
        if (r) begin
            m_phase = 0;
            m_cnt   = 0;
            m_run   = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_lost  = 1'b0;
        end else begin
            old_s2 = m_s2;
            m_s2   = m_s1;
            m_s1   = lk;
            case (m_phase)
                0: begin
                    if (old_s2) begin
                        m_phase = 1;
                        m_cnt   = 0;
                    end
                end
                1: begin
                    if (!old_s2) begin
                        m_phase = 0;
                    end else if (m_cnt == SETTLE - 1) begin
                        m_phase = 2;
                        m_run   = 0;
                    end else begin
                        m_cnt++;
                    end
                end
                default: begin
`ifdef PLL_LOCK_LOSS_EN
                    if (!old_s2) begin
                        m_phase = 0;
                        m_lost  = 1'b1;
                    end else begin
                        m_run++;
                    end
`else
                    m_run++;
`endif
                end
            endcase
        end
    endtask

    // Drive one cycle of stimulus, queue the model's prediction, then compare
    // against the DUT one time unit after the edge.
    task automatic step(input logic r, input logic lk);
        exp_t e;
        reset  = r;
        locked = lk;
        model_edge(r, lk);
        e.rst_out   = (m_phase != 2);
        e.ce_pix    = (m_phase == 2) && ((m_run % PIX) == PIX - 1);
        e.ce_cpu    = (m_phase == 2) && ((m_run % CPU) == CPU - 1);
        e.lock_sync = m_s2;
        e.lock_lost = m_lost;
        sb.push_back(e);
        @(posedge clk_sys);
        #1;
        e = sb.pop_front();
        chk("sb_rst_out",   rst_out,   e.rst_out);
        chk("sb_ce_pix",    ce_pix,    e.ce_pix);
        chk("sb_ce_cpu",    ce_cpu,    e.ce_cpu);
        chk("sb_lock_sync", lock_sync, e.lock_sync);
        chk("sb_lock_lost", lock_lost, e.lock_lost);
    endtask

    // Hold locked high and count edges until rst_out falls (bounded).
    task automatic wait_release(input string nm);
        int n;
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            step(1'b0, 1'b1);
            if (rst_out === 1'b0) begin
                n = k;
                break;
            end
        end
        chk_int(nm, n, SETTLE + 3);
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic lk, input int n,
                                input logic e_rst, input logic e_pix, input logic e_cpu,
                                input logic e_sync, input logic e_lost);
        vec_t v;
        v.name   = name;
        v.r      = r;
        v.lk     = lk;
        v.n      = n;
        v.e_rst  = e_rst;
        v.e_pix  = e_pix;
        v.e_cpu  = e_cpu;
        v.e_sync = e_sync;
        v.e_lost = e_lost;
        return v;
    endfunction

    initial begin
        int   last_pix;
        int   last_cpu;
        int   cyc;
        logic prev_pix;
        int   n_rise;
        int   pix_cnt;

        // Power-up sequence with SETTLE=16: release at edge 19, first ce_pix in
        // cycle 4 after release, first ce_cpu in cycle 8.
        vecs[0] = mk("init_reset",   1'b1, 1'b1, 3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk("pre_release",  1'b0, 1'b1, 18, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[2] = mk("release_e19",  1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[3] = mk("first_pix_c4", 1'b0, 1'b1, 3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[4] = mk("first_cpu_c8", 1'b0, 1'b1, 4,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[5] = mk("cycle9_idle",  1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < vecs[v].n; c++) begin
                step(vecs[v].r, vecs[v].lk);
            end
            chk({vecs[v].name, "_rst_out"},   rst_out,   vecs[v].e_rst);
            chk({vecs[v].name, "_ce_pix"},    ce_pix,    vecs[v].e_pix);
            chk({vecs[v].name, "_ce_cpu"},    ce_cpu,    vecs[v].e_cpu);
            chk({vecs[v].name, "_lock_sync"}, lock_sync, vecs[v].e_sync);
            chk({vecs[v].name, "_lock_lost"}, lock_lost, vecs[v].e_lost);
        end

        // Cadence over 1000 cycles: fixed periods, cpu inside pix, no back-to-back pix.
        last_pix = 8;
        last_cpu = 8;
        prev_pix = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'b1);
            cyc = 10 + i;
            if (ce_pix === 1'b1) begin
                chk_int("pix_period", cyc - last_pix, PIX);
                last_pix = cyc;
            end
            if (ce_cpu === 1'b1) begin
                chk("cpu_with_pix", ce_pix, 1'b1);
                chk_int("cpu_period", cyc - last_cpu, CPU);
                last_cpu = cyc;
            end
            chk("pix_back_to_back", ce_pix & prev_pix, 1'b0);
            prev_pix = ce_pix;
        end

        // One-cycle lock glitch at settle count 10: settle must restart.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        wait_release("glitch_release_edges");

        // Lock drop while running.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        n_rise  = 0;
        pix_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0);
            if ((rst_out === 1'b1) && (n_rise == 0)) n_rise = k;
            if (ce_pix === 1'b1) pix_cnt++;
        end
`ifdef PLL_LOCK_LOSS_EN
        chk("lockloss_rst_within3", (n_rise >= 1) && (n_rise <= 3), 1'b1);
        chk("lockloss_ce_pix_stopped", ce_pix, 1'b0);
        chk("lockloss_flag", lock_lost, 1'b1);
        wait_release("relock_release_edges");
        chk("lockloss_flag_sticky", lock_lost, 1'b1);
`else
        chk_int("nolossen_rst_stays_low", n_rise, 0);
        chk_int("nolossen_pix_continue", pix_cnt, 2);
        chk("nolossen_flag_zero", lock_lost, 1'b0);
`endif

        // Reset asserted for one cycle in RUN restarts the whole sequence.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("midrun_reset_rst_out", rst_out, 1'b1);
        chk("midrun_reset_ce_pix", ce_pix, 1'b0);
        chk("midrun_reset_lock_sync", lock_sync, 1'b0);
        chk("midrun_reset_lock_lost", lock_lost, 1'b0);
        wait_release("midrun_reset_release_edges");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
